// File: rtl/multdiv_issue.sv
// Issues one MULT/DIV to the multdiv unit, stalls the pipeline until the result is ready, then writes it back for one cycle.
// Optional MULTDIV_TIMEOUT_EN: forces an exception writeback after TIMEOUT_CYCLES WAIT cycles with no result-ready.
module multdiv_issue #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int STATUS_REG     = 30,
    parameter int MULT_STATUS    = 4,
    parameter int DIV_STATUS     = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_is_div,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy
);

    localparam logic [4:0]  STATUS_RD = 5'(STATUS_REG);
    localparam logic [31:0] MULT_ST   = 32'(MULT_STATUS);
    localparam logic [31:0] DIV_ST    = 32'(DIV_STATUS);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic [4:0]  rd_q, rd_d;
    logic        div_q, div_d, exc_q, exc_d;
    logic        guard_q, guard_d;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_q, tmo_d;
`endif

    assign md_operandA = opa_q;
    assign md_operandB = opb_q;
    assign busy        = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        rd_d         = rd_q;
        div_d        = div_q;
        res_d        = res_q;
        exc_d        = exc_q;
        guard_d      = guard_q;
`ifdef MULTDIV_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        stall        = 1'b0;
        md_ctrl_MULT = 1'b0;
        md_ctrl_DIV  = 1'b0;
        wb_valid     = 1'b0;
        wb_rd        = 5'd0;
        wb_data      = 32'd0;

        case (state_q)
            S_IDLE: begin
                // Stall combinationally so the request cannot slip past before it is latched.
                stall = req_valid;
                if (req_valid) begin
                    opa_d   = req_a;
                    opb_d   = req_b;
                    rd_d    = req_rd;
                    div_d   = req_is_div;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                stall        = 1'b1;
                md_ctrl_DIV  = div_q;
                md_ctrl_MULT = ~div_q;
                guard_d      = 1'b1;
`ifdef MULTDIV_TIMEOUT_EN
                tmo_d        = '0;
`endif
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                stall   = 1'b1;
                guard_d = 1'b0;
                // Ready in the first WAIT cycle may still belong to the previous operation.
                if (!guard_q && md_resultRDY) begin
                    res_d   = md_result;
                    exc_d   = md_exception;
                    state_d = S_DONE;
                end
`ifdef MULTDIV_TIMEOUT_EN
                else if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    res_d   = 32'd0;
                    exc_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
`endif
            end
            S_DONE: begin
                wb_valid = 1'b1;
                wb_rd    = exc_q ? STATUS_RD : rd_q;
                wb_data  = exc_q ? (div_q ? DIV_ST : MULT_ST) : res_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            res_q   <= 32'd0;
            rd_q    <= 5'd0;
            div_q   <= 1'b0;
            exc_q   <= 1'b0;
            guard_q <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
            div_q   <= div_d;
            exc_q   <= exc_d;
            guard_q <= guard_d;
`ifdef MULTDIV_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

endmodule

// File: doc/multdiv_issue.md
Name: multdiv_issue

Overview:
- CPU-side initiator for the multiply/divide unit. Accepts a MULT/DIV request from the execute stage and latches the operands and destination register.
- Pulses the unit's start control for one cycle, then holds operands stable and stalls the pipeline until result-ready.
- Delivers a one-cycle writeback: the result to rd, or the exception status to rstatus (r30).
- Sits between the execute stage and multdiv; register file write mux and stall logic consume its outputs.

Parameters:
- TIMEOUT_CYCLES, 40, max WAIT cycles before forced completion (used only with MULTDIV_TIMEOUT_EN).
- STATUS_REG, 30, register written on exception.
- MULT_STATUS, 4, rstatus value on multiply overflow.
- DIV_STATUS, 5, rstatus value on divide exception.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  execute stage holds a MULT/DIV instruction.
- req_is_div  in  1  1=DIV, 0=MULT.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_rd  in  5  destination register.
- stall  out  1  freeze fetch/decode/execute.
- md_operandA  out  32  to multdiv data_operandA.
- md_operandB  out  32  to multdiv data_operandB.
- md_ctrl_MULT  out  1  one-cycle start pulse.
- md_ctrl_DIV  out  1  one-cycle start pulse.
- md_result  in  32  multdiv data_result.
- md_exception  in  1  multdiv data_exception.
- md_resultRDY  in  1  multdiv data_resultRDY.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback value.
- busy  out  1  high in LAUNCH/WAIT/DONE.

Behaviour:
- Clock port is clock; reset port is reset. Reset is synchronous and active-high, sampled only on the rising clock edge.
- States: IDLE, LAUNCH, WAIT, DONE. Encoding is free.
- Reset values: state=IDLE, all registered outputs 0, operand/rd/op latches 0, guard and timeout counter 0.
- IDLE:
  - stall = req_valid (combinational) so the instruction never advances unserved.
  - On req_valid, latch req_a/req_b/req_rd/req_is_div and go to LAUNCH.
- LAUNCH (1 cycle):
  - md_ctrl_DIV=op, md_ctrl_MULT=~op; exactly one is high for exactly one cycle.
  - stall=1. Next state is WAIT.
- WAIT:
  - stall=1. Operands are held on md_operandA/B from LAUNCH through WAIT, unchanged.
  - md_resultRDY is ignored in the first WAIT cycle (guard against stale ready from the previous op).
  - From the second WAIT cycle, md_resultRDY=1 captures md_result and md_exception into registers and moves to DONE.
- DONE (1 cycle):
  - stall=0. wb_valid=1.
  - If the captured exception is 0: wb_rd=latched rd, wb_data=captured result.
  - If the captured exception is 1: wb_rd=STATUS_REG, wb_data=DIV_STATUS if op was DIV, else MULT_STATUS.
  - Next state is IDLE.
  - req_valid during DONE is the instruction being retired and is ignored.
- Outside DONE: wb_valid=0 and wb_rd/wb_data=0.
- Latency: request seen in cycle 0, ctrl pulse in cycle 1, earliest wb_valid in cycle 4. Stall is high in cycles 0 through (wb cycle − 1).
- Back-to-back: a new request in the cycle after DONE is accepted normally from IDLE.
- Reset mid-operation (LAUNCH/WAIT/DONE):
  - Return to IDLE next edge; no wb_valid is issued; the aborted op is lost.
  - multdiv is not cleared. Its restart occurs on the next ctrl pulse.
- md_resultRDY while in IDLE/LAUNCH is ignored.
- Width rules: wb_data is exactly 32 bits, with no sign extension or other processing. MULT_STATUS/DIV_STATUS are zero-extended to 32.

Optional Feature:
- Macro: MULTDIV_TIMEOUT_EN.
- Defined:
  - A counter clears on LAUNCH and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without md_resultRDY, go to DONE with the exception forced. Writeback is STATUS_REG with DIV_STATUS/MULT_STATUS per op.
  - md_resultRDY in the same cycle as the timeout takes priority (normal capture).
- Undefined: no counter is present; WAIT waits indefinitely.

Test Plan:
- MULT 7×6, rd=3 → exactly one md_ctrl_MULT pulse. Stall high until the wb cycle, then wb_valid with wb_rd=3, wb_data=42.
- DIV 100/7, rd=9 → one md_ctrl_DIV pulse, then wb_rd=9, wb_data=14. Operands remain 100/7 throughout WAIT.
- DIV 5/0 (multdiv raises exception with resultRDY) → wb_rd=30, wb_data=5. MULT 0x00010000×0x00010000 (overflow) → wb_rd=30, wb_data=4.
- Model holds md_resultRDY=1 (stale) through LAUNCH and the first WAIT cycle, with the real result arriving 10 cycles later → stale ready is ignored. Capture happens on the real result, and a req_valid held during DONE does not relaunch.
- Assert reset in the 5th WAIT cycle → IDLE next cycle, stall=0, no wb_valid. A following MULT 3×3 completes with wb_data=9.
- With MULTDIV_TIMEOUT_EN and md_resultRDY tied 0, MULT → wb_valid occurs TIMEOUT_CYCLES WAIT cycles after LAUNCH, with wb_rd=30, wb_data=4.
